// File: rtl/sub_sample_ctrl_if.sv
// Bus bundle for sub_sample_ctrl: pixel input handshake, neighbourhood output to
// sub_sample, the sub_sample result input and the tagged pooled-result output.
interface sub_sample_ctrl_if #(
    parameter int NN_WIDTH = 8,
    parameter int POOL     = 2,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8
);
    localparam int NH_W  = POOL * POOL * NN_WIDTH;
    localparam int COL_W = (IMG_W / POOL > 1) ? $clog2(IMG_W / POOL) : 1;
    localparam int ROW_W = (IMG_H / POOL > 1) ? $clog2(IMG_H / POOL) : 1;

    logic [NN_WIDTH-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [NH_W-1:0]     nh_vector;
    logic                nh_valid;
    logic [NN_WIDTH-1:0] ss_result;
    logic [NN_WIDTH-1:0] out_data;
    logic                out_valid;
    logic [COL_W-1:0]    out_col;
    logic [ROW_W-1:0]    out_row;
    logic                frame_done;

    modport slave (
        input  in_data, in_valid, ss_result,
        output in_ready, nh_vector, nh_valid, out_data, out_valid, out_col, out_row, frame_done
    );

    modport master (
        output in_data, in_valid, ss_result,
        input  in_ready, nh_vector, nh_valid, out_data, out_valid, out_col, out_row, frame_done
    );
endinterface

// File: rtl/sub_sample_ctrl.sv
// Band-buffering sequencer for the sub_sample mean-pooling block: fills POOL rows,
// emits one POOLxPOOL window per cycle and tags results. Optional SUB_SAMPLE_CTRL_PERF_EN adds stall_cycles.
module sub_sample_ctrl #(
    parameter int NN_WIDTH   = 8,
    parameter int POOL       = 2,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int SS_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    sub_sample_ctrl_if.slave  bus
`ifdef SUB_SAMPLE_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);
    localparam int NH_W  = POOL * POOL * NN_WIDTH;
    localparam int NWIN  = IMG_W / POOL;
    localparam int NBAND = IMG_H / POOL;
    localparam int BUF_N = POOL * IMG_W;
    localparam int PTR_W = $clog2(BUF_N);
    localparam int COL_W = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int ROW_W = (NBAND > 1) ? $clog2(NBAND) : 1;

    typedef enum logic [1:0] {FILL, EMIT, DRAIN} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [ROW_W-1:0]    band_q;
    logic [COL_W-1:0]    win_q;
    logic                in_ready_q;
    logic [NN_WIDTH-1:0] buf_q [BUF_N];

    logic [NH_W-1:0]     nh_vector_d;
    logic [NH_W-1:0]     nh_vector_q;
    logic                nh_valid_q;
    logic [ROW_W-1:0]    nh_row_q;
    logic [COL_W-1:0]    nh_col_q;
    logic [PTR_W-1:0]    rd_idx;

    logic [SS_LATENCY-1:0] dl_valid_q;
    logic [ROW_W-1:0]      dl_row_q [SS_LATENCY];
    logic [COL_W-1:0]      dl_col_q [SS_LATENCY];

    logic [NN_WIDTH-1:0] out_data_q;
    logic                out_valid_q;
    logic [COL_W-1:0]    out_col_q;
    logic [ROW_W-1:0]    out_row_q;
    logic                frame_done_q;

    logic accept;
    logic dl_out_valid;

    assign accept       = bus.in_valid & in_ready_q;
    assign dl_out_valid = dl_valid_q[SS_LATENCY-1];

    // NOTE: the band buffer carries no reset; FILL always rewrites every entry
    // before EMIT reads it, so stale contents can never reach nh_vector.
    always_ff @(posedge clock) begin
        if (accept) buf_q[ptr_q] <= bus.in_data;
    end

    // NOTE: every variable written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        nh_vector_d = '0;
        rd_idx      = '0;
        for (int r = 0; r < POOL; r++) begin
            for (int c = 0; c < POOL; c++) begin
                rd_idx = PTR_W'(r * IMG_W + c) + PTR_W'(win_q) * PTR_W'(POOL);
                nh_vector_d[(r * POOL + c) * NN_WIDTH +: NN_WIDTH] = buf_q[rd_idx];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FILL;
            ptr_q        <= '0;
            band_q       <= '0;
            win_q        <= '0;
            in_ready_q   <= 1'b0;
            nh_vector_q  <= '0;
            nh_valid_q   <= 1'b0;
            nh_row_q     <= '0;
            nh_col_q     <= '0;
            dl_valid_q   <= '0;
            for (int i = 0; i < SS_LATENCY; i++) begin
                dl_row_q[i] <= '0;
                dl_col_q[i] <= '0;
            end
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            nh_valid_q <= 1'b0;
            case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (ptr_q == PTR_W'(BUF_N - 1)) begin
                            ptr_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= EMIT;
                        end else begin
                            ptr_q <= ptr_q + PTR_W'(1);
                        end
                    end
                end
                EMIT: begin
                    nh_vector_q <= nh_vector_d;
                    nh_valid_q  <= 1'b1;
                    nh_row_q    <= band_q;
                    nh_col_q    <= win_q;
                    if (win_q == COL_W'(NWIN - 1)) begin
                        win_q <= '0;
                        if (band_q == ROW_W'(NBAND - 1)) begin
                            state_q <= DRAIN;
                        end else begin
                            band_q     <= band_q + ROW_W'(1);
                            in_ready_q <= 1'b1;
                            state_q    <= FILL;
                        end
                    end else begin
                        win_q <= win_q + COL_W'(1);
                    end
                end
                DRAIN: begin
                    // The last window may still sit in nh_valid_q before entering the delay line.
                    if (!nh_valid_q && dl_valid_q == '0) begin
                        band_q     <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase

            dl_valid_q[0] <= nh_valid_q;
            dl_row_q[0]   <= nh_row_q;
            dl_col_q[0]   <= nh_col_q;
            for (int i = 1; i < SS_LATENCY; i++) begin
                dl_valid_q[i] <= dl_valid_q[i-1];
                dl_row_q[i]   <= dl_row_q[i-1];
                dl_col_q[i]   <= dl_col_q[i-1];
            end

            out_valid_q  <= dl_out_valid;
            frame_done_q <= dl_out_valid
                          && dl_row_q[SS_LATENCY-1] == ROW_W'(NBAND - 1)
                          && dl_col_q[SS_LATENCY-1] == COL_W'(NWIN - 1);
            if (dl_out_valid) begin
                out_data_q <= bus.ss_result;
                out_row_q  <= dl_row_q[SS_LATENCY-1];
                out_col_q  <= dl_col_q[SS_LATENCY-1];
            end
        end
    end

`ifdef SUB_SAMPLE_CTRL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (bus.in_valid && !in_ready_q && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign bus.in_ready   = in_ready_q;
    assign bus.nh_vector  = nh_vector_q;
    assign bus.nh_valid   = nh_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_row    = out_row_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sub_sample_ctrl.sv
// Self-checking bench for sub_sample_ctrl: drives whole frames, models sub_sample as a
// floor-mean pipe and checks windows, results, tags, timing and reset against image arithmetic.
module tb_sub_sample_ctrl;
    localparam int NN_WIDTH = 8;
    localparam int POOL     = 2;
    localparam int IMG_W    = 4;
    localparam int IMG_H    = 4;
    localparam int SS_LAT   = 1;

    localparam int NHS      = POOL * POOL;
    localparam int NWIN     = IMG_W / POOL;
    localparam int NBAND    = IMG_H / POOL;
    localparam int BAND_PIX = POOL * IMG_W;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int NRES     = NWIN * NBAND;
    localparam int NH_W     = NHS * NN_WIDTH;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sub_sample_ctrl_if #(.NN_WIDTH(NN_WIDTH), .POOL(POOL), .IMG_W(IMG_W), .IMG_H(IMG_H)) ifc ();

`ifdef SUB_SAMPLE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    sub_sample_ctrl #(
        .NN_WIDTH(NN_WIDTH), .POOL(POOL), .IMG_W(IMG_W), .IMG_H(IMG_H), .SS_LATENCY(SS_LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
`ifdef SUB_SAMPLE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // sub_sample stand-in: floor mean of the vector, SS_LAT register stages, no reset.
    logic [NN_WIDTH-1:0] ss_pipe [SS_LAT];

    function automatic logic [NN_WIDTH-1:0] floor_mean(input logic [NH_W-1:0] v);
        int s;
        s = 0;
        for (int k = 0; k < NHS; k++) s += int'(v[k*NN_WIDTH +: NN_WIDTH]);
        return NN_WIDTH'(s / NHS);
    endfunction

    always @(posedge clock) begin
        ss_pipe[0] <= floor_mean(ifc.nh_vector);
        for (int i = 1; i < SS_LAT; i++) ss_pipe[i] <= ss_pipe[i-1];
    end
    assign ifc.ss_result = ss_pipe[SS_LAT-1];

    // Observation queues filled on the falling edge.
    typedef struct { int cyc; logic [NH_W-1:0] vec; } nh_rec_t;
    typedef struct { int cyc; logic [NN_WIDTH-1:0] data; int row; int col; logic fd; } out_rec_t;

    int                  cyc = 0;
    nh_rec_t             nh_q [$];
    out_rec_t            out_q [$];
    int                  acc_cyc [$];
    logic [NN_WIDTH-1:0] acc_dat [$];
    int                  fd_cnt = 0;
    int                  stall_ref = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            if (ifc.nh_valid) nh_q.push_back('{cyc: cyc, vec: ifc.nh_vector});
            if (ifc.out_valid)
                out_q.push_back('{cyc: cyc, data: ifc.out_data, row: int'(ifc.out_row),
                                  col: int'(ifc.out_col), fd: ifc.frame_done});
            if (ifc.frame_done) fd_cnt++;
            if (ifc.in_valid && ifc.in_ready) begin
                acc_cyc.push_back(cyc);
                acc_dat.push_back(ifc.in_data);
            end
            if (ifc.in_valid && !ifc.in_ready) stall_ref++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: in_valid held high; mode 1: one idle cycle before each pixel; mode 2: random idles.
    task automatic drive_pixel(input logic [NN_WIDTH-1:0] d, input int mode, output bit ok);
        ok = 1'b0;
        if (mode == 1 || (mode == 2 && $urandom_range(0, 99) < 30)) begin
            ifc.in_valid = 1'b0;
            @(posedge clock); #1;
        end
        ifc.in_data  = d;
        ifc.in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clock);
            if (ifc.in_ready) ok = 1'b1;
            @(posedge clock); #1;
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic run_frames(input string name, input int nf, input int mode, input bit ramp);
        logic [NN_WIDTH-1:0] pix [$];
        logic [NH_W-1:0]     exp_vec;
        bit                  ok;
        int                  sum, f, j, b, w, base, idx;

        nh_q.delete(); out_q.delete(); acc_cyc.delete(); acc_dat.delete();
        fd_cnt = 0;
        for (int i = 0; i < nf * NPIX; i++)
            pix.push_back(ramp ? NN_WIDTH'(i % NPIX) : NN_WIDTH'($urandom));

        for (int i = 0; i < nf * NPIX; i++) begin
            drive_pixel(pix[i], mode, ok);
            if (!ok) begin
                check($sformatf("%s accept_timeout pixel %0d", name, i), 64'(ok), 64'(1));
                break;
            end
        end
        for (int t = 0; t < 500 && out_q.size() < nf * NRES; t++) @(posedge clock);
        repeat (SS_LAT + 4) @(posedge clock);
        #1;

        check({name, " accept_count"}, 64'(acc_dat.size()), 64'(nf * NPIX));
        check({name, " nh_count"},     64'(nh_q.size()),    64'(nf * NRES));
        check({name, " out_count"},    64'(out_q.size()),   64'(nf * NRES));
        check({name, " frame_done_count"}, 64'(fd_cnt), 64'(nf));

        for (int i = 0; i < nf * NPIX && i < acc_dat.size(); i++)
            check($sformatf("%s accept_data %0d", name, i), 64'(acc_dat[i]), 64'(pix[i]));

        for (int i = 0; i < nf * NRES && i < nh_q.size() && i < out_q.size(); i++) begin
            f = i / NRES; j = i % NRES; b = j / NWIN; w = j % NWIN;
            base = f * NPIX;
            exp_vec = '0;
            sum = 0;
            for (int r = 0; r < POOL; r++)
                for (int c = 0; c < POOL; c++) begin
                    idx = base + (b * POOL + r) * IMG_W + w * POOL + c;
                    exp_vec[(r * POOL + c) * NN_WIDTH +: NN_WIDTH] = pix[idx];
                    sum += int'(pix[idx]);
                end
            check($sformatf("%s nh_vector %0d", name, i), 64'(nh_q[i].vec), 64'(exp_vec));
            check($sformatf("%s out_data %0d", name, i), 64'(out_q[i].data), 64'(sum / NHS));
            check($sformatf("%s out_row %0d", name, i), 64'(out_q[i].row), 64'(b));
            check($sformatf("%s out_col %0d", name, i), 64'(out_q[i].col), 64'(w));
            check($sformatf("%s frame_done %0d", name, i), 64'(out_q[i].fd), 64'(j == NRES - 1));
            check($sformatf("%s latency %0d", name, i),
                  64'(out_q[i].cyc - nh_q[i].cyc), 64'(SS_LAT + 1));
            if (w > 0)
                check($sformatf("%s nh_back_to_back %0d", name, i),
                      64'(nh_q[i].cyc - nh_q[i-1].cyc), 64'(1));
        end

        for (int g = 1; g < nf * NBAND && g * BAND_PIX < acc_cyc.size(); g++) begin
            idx = g * BAND_PIX;
            if (g % NBAND != 0) begin
                if (mode == 0)
                    check($sformatf("%s emit_stall band %0d", name, g),
                          64'(acc_cyc[idx] - acc_cyc[idx-1]), 64'(NWIN + 1));
            end else if ((g / NBAND) * NRES <= out_q.size()) begin
                check($sformatf("%s drain_hold frame %0d", name, g / NBAND),
                      64'(acc_cyc[idx] > out_q[(g / NBAND) * NRES - 1].cyc), 64'(1));
            end
        end

        if (mode == 1)
            for (int g = 0; g < nf * NBAND && (g + 1) * BAND_PIX <= acc_cyc.size(); g++)
                check($sformatf("%s fill_span band %0d", name, g),
                      64'(acc_cyc[(g + 1) * BAND_PIX - 1] - acc_cyc[g * BAND_PIX]),
                      64'(2 * (BAND_PIX - 1)));

`ifdef SUB_SAMPLE_CTRL_PERF_EN
        check({name, " stall_cycles"}, 64'(stall_cycles), 64'(stall_ref));
`endif
    endtask

    initial begin : main
        bit  ok;
        int  n_out_before;

        ifc.in_data  = '0;
        ifc.in_valid = 1'b0;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst in_ready",   64'(ifc.in_ready),   64'(0));
        check("rst nh_valid",   64'(ifc.nh_valid),   64'(0));
        check("rst nh_vector",  64'(ifc.nh_vector),  64'(0));
        check("rst out_valid",  64'(ifc.out_valid),  64'(0));
        check("rst out_data",   64'(ifc.out_data),   64'(0));
        check("rst out_col",    64'(ifc.out_col),    64'(0));
        check("rst out_row",    64'(ifc.out_row),    64'(0));
        check("rst frame_done", 64'(ifc.frame_done), 64'(0));
`ifdef SUB_SAMPLE_CTRL_PERF_EN
        check("rst stall_cycles", 64'(stall_cycles), 64'(0));
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("in_ready before first edge", 64'(ifc.in_ready), 64'(0));
        @(negedge clock);
        check("in_ready after first edge", 64'(ifc.in_ready), 64'(1));
        @(posedge clock); #1;

        run_frames("ramp_cont_x2", 2, 0, 1'b1);
        run_frames("ramp_toggle",  1, 1, 1'b1);
        run_frames("rand_gaps_x2", 2, 2, 1'b0);
        run_frames("rand_cont",    1, 0, 1'b0);

        // Reset one cycle after the first window of band 1 appears.
        nh_q.delete(); out_q.delete(); acc_cyc.delete(); acc_dat.delete();
        fd_cnt = 0;
        for (int i = 0; i < 2 * BAND_PIX; i++) begin
            drive_pixel(NN_WIDTH'(i), 0, ok);
            if (!ok) begin
                check("midrst accept_timeout", 64'(ok), 64'(1));
                break;
            end
        end
        for (int t = 0; t < 100 && nh_q.size() < NWIN + 1; t++) begin
            @(posedge clock); #1;
        end
        check("midrst band1 window seen", 64'(nh_q.size() >= NWIN + 1), 64'(1));
        n_out_before = out_q.size();
        reset = 1'b1;
        stall_ref = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrst out_valid",  64'(ifc.out_valid), 64'(0));
        check("midrst nh_valid",   64'(ifc.nh_valid),  64'(0));
        check("midrst in_ready",   64'(ifc.in_ready),  64'(0));
        check("midrst out_data",   64'(ifc.out_data),  64'(0));
        repeat (20) @(posedge clock);
        #1;
        check("midrst no late out_valid", 64'(out_q.size()), 64'(n_out_before));
        check("midrst no frame_done",     64'(fd_cnt),        64'(0));
        check("midrst in_ready back",     64'(ifc.in_ready),  64'(1));

        run_frames("ramp_after_reset", 1, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
